// File: rtl/mat_pkg.sv
// Shared types for the 4x4 block sequencer: sizes, FSM states, issue tag.
// Element index helper maps (block row, row, block col, col) to row-major.
package mat_pkg;

  localparam int DEF_W = 32;
  localparam int MAT_N = 4;
  localparam int TILE  = 2;

  typedef enum logic [1:0] {
    LOAD,
    ISSUE,
    DRAIN,
    OUTPUT
  } state_t;

  typedef struct packed {
    logic valid;
    logic i;
    logic j;
    logic kk;
  } tag_t;

  function automatic logic [3:0] el_idx(
    input logic br,
    input logic r,
    input logic bc,
    input logic c
  );
    return {br, r, bc, c};
  endfunction

endpackage

// File: rtl/mat_tag_pipe.sv
// Delay line carrying {valid,i,j,kk} alongside each core issue.
// Ports: clk, rst, tag_in, tag_out (DEPTH cycles later), busy (any stage valid).
module mat_tag_pipe
  import mat_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_in,
  output tag_t tag_out,
  output logic busy
);

  tag_t stg [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++)
        stg[k] <= '0;
    end else begin
      stg[0] <= tag_in;
      for (int k = 1; k < DEPTH; k++)
        stg[k] <= stg[k-1];
    end
  end

  assign tag_out = stg[DEPTH-1];

  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < DEPTH; k++)
      busy = busy | stg[k].valid;
  end

endmodule

// File: rtl/mat4_block_sequencer.sv
// Loads A,B (32 words), issues 8 2x2 block products, accumulates, streams C.
// Ports: in_* word stream, core_a*/core_b* operands, core_c* results, out_* stream, busy.
module mat4_block_sequencer
  import mat_pkg::*;
#(
  parameter int W        = DEF_W,
  parameter int CORE_LAT = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic [W-1:0] core_a11,
  output logic [W-1:0] core_a12,
  output logic [W-1:0] core_a21,
  output logic [W-1:0] core_a22,
  output logic [W-1:0] core_b11,
  output logic [W-1:0] core_b12,
  output logic [W-1:0] core_b21,
  output logic [W-1:0] core_b22,
  input  logic [W-1:0] core_c11,
  input  logic [W-1:0] core_c12,
  input  logic [W-1:0] core_c21,
  input  logic [W-1:0] core_c22,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         busy
);

  localparam int NEL = MAT_N * MAT_N;

  state_t       state, state_n;
  logic [4:0]   cnt;
  logic [W-1:0] a_m [NEL];
  logic [W-1:0] b_m [NEL];
  logic [W-1:0] c_m [NEL];
  tag_t         tag_in, tag_out;
  logic         pipe_busy;
  logic         ld_fire, out_fire;
  logic         iss_i, iss_j, iss_k;
  logic [3:0]   ci11, ci12, ci21, ci22;

  assign ld_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // issue slot n decodes directly to (i,j,kk)
  assign {iss_i, iss_j, iss_k} = cnt[2:0];

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    busy      = 1'b1;
    tag_in    = '0;
    unique case (state)
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (ld_fire && cnt == 5'd31)
          state_n = ISSUE;
      end
      ISSUE: begin
        tag_in.valid = 1'b1;
        tag_in.i     = iss_i;
        tag_in.j     = iss_j;
        tag_in.kk    = iss_k;
        if (cnt == 5'd7)
          state_n = DRAIN;
      end
      DRAIN: begin
        if (!pipe_busy)
          state_n = OUTPUT;
      end
      OUTPUT: begin
        out_valid = 1'b1;
        out_data  = c_m[cnt[3:0]];
        if (out_fire && cnt == 5'd15)
          state_n = LOAD;
      end
      default: state_n = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= LOAD;
    else
      state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      unique case (state)
        LOAD:   if (ld_fire) cnt <= cnt + 5'd1;
        ISSUE:  cnt <= (cnt == 5'd7) ? '0 : cnt + 5'd1;
        DRAIN:  cnt <= '0;
        OUTPUT: if (out_fire) cnt <= (cnt == 5'd15) ? '0 : cnt + 5'd1;
        default: cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NEL; k++) begin
        a_m[k] <= '0;
        b_m[k] <= '0;
      end
    end else if (ld_fire) begin
      if (!cnt[4])
        a_m[cnt[3:0]] <= in_data;
      else
        b_m[cnt[3:0]] <= in_data;
    end
  end

  // A block (i,kk) times B block (kk,j)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_a11 <= '0;
      core_a12 <= '0;
      core_a21 <= '0;
      core_a22 <= '0;
      core_b11 <= '0;
      core_b12 <= '0;
      core_b21 <= '0;
      core_b22 <= '0;
    end else if (state == ISSUE) begin
      core_a11 <= a_m[el_idx(iss_i, 1'b0, iss_k, 1'b0)];
      core_a12 <= a_m[el_idx(iss_i, 1'b0, iss_k, 1'b1)];
      core_a21 <= a_m[el_idx(iss_i, 1'b1, iss_k, 1'b0)];
      core_a22 <= a_m[el_idx(iss_i, 1'b1, iss_k, 1'b1)];
      core_b11 <= b_m[el_idx(iss_k, 1'b0, iss_j, 1'b0)];
      core_b12 <= b_m[el_idx(iss_k, 1'b0, iss_j, 1'b1)];
      core_b21 <= b_m[el_idx(iss_k, 1'b1, iss_j, 1'b0)];
      core_b22 <= b_m[el_idx(iss_k, 1'b1, iss_j, 1'b1)];
    end else begin
      core_a11 <= '0;
      core_a12 <= '0;
      core_a21 <= '0;
      core_a22 <= '0;
      core_b11 <= '0;
      core_b12 <= '0;
      core_b21 <= '0;
      core_b22 <= '0;
    end
  end

  mat_tag_pipe #(
    .DEPTH(CORE_LAT)
  ) u_tags (
    .clk    (clk),
    .rst    (rst),
    .tag_in (tag_in),
    .tag_out(tag_out),
    .busy   (pipe_busy)
  );

  assign ci11 = el_idx(tag_out.i, 1'b0, tag_out.j, 1'b0);
  assign ci12 = el_idx(tag_out.i, 1'b0, tag_out.j, 1'b1);
  assign ci21 = el_idx(tag_out.i, 1'b1, tag_out.j, 1'b0);
  assign ci22 = el_idx(tag_out.i, 1'b1, tag_out.j, 1'b1);

  // kk=0 lands first and seeds the block; kk=1 follows a cycle later and adds
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NEL; k++)
        c_m[k] <= '0;
    end else if (tag_out.valid) begin
      if (tag_out.kk) begin
        c_m[ci11] <= c_m[ci11] + core_c11;
        c_m[ci12] <= c_m[ci12] + core_c12;
        c_m[ci21] <= c_m[ci21] + core_c21;
        c_m[ci22] <= c_m[ci22] + core_c22;
      end else begin
        c_m[ci11] <= core_c11;
        c_m[ci12] <= core_c12;
        c_m[ci21] <= core_c21;
        c_m[ci22] <= core_c22;
      end
    end
  end

endmodule

// File: tb/tb_mat4_block_sequencer.sv
// Bench for mat4_block_sequencer: three instances (CORE_LAT 3,1,8) each
// driving a behavioural 2x2 core; vector table plus reset-mid-issue sequence.
module tb_mat4_block_sequencer;

  typedef struct packed {
    logic [15:0][31:0] a;
    logic [15:0][31:0] b;
    logic [15:0][31:0] c;
    logic [1:0]        sel;
    logic [7:0]        rdy_pct;
    logic              hold;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_data = '0;
  logic [1:0]  sel = 2'd0;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  logic [2:0]  ov_v, ir_v, bz_v, cz_v;
  logic [31:0] od_v [3];
  logic        ov, ir, bz, cz;
  logic [31:0] od;

  assign ov = ov_v[sel];
  assign ir = ir_v[sel];
  assign bz = bz_v[sel];
  assign cz = cz_v[sel];
  assign od = od_v[sel];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int L = (g == 0) ? 3 : (g == 1) ? 1 : 8;
    logic [31:0] a11, a12, a21, a22, b11, b12, b21, b22;
    logic [31:0] c11, c12, c21, c22;
    logic [31:0] p11, p12, p21, p22;
    logic        ovl, irl, bzl;
    logic [31:0] odl;

    mat4_block_sequencer #(
      .W(32),
      .CORE_LAT(L)
    ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid && (sel == 2'(g))),
      .in_ready (irl),
      .in_data  (in_data),
      .core_a11 (a11),
      .core_a12 (a12),
      .core_a21 (a21),
      .core_a22 (a22),
      .core_b11 (b11),
      .core_b12 (b12),
      .core_b21 (b21),
      .core_b22 (b22),
      .core_c11 (c11),
      .core_c12 (c12),
      .core_c21 (c21),
      .core_c22 (c22),
      .out_valid(ovl),
      .out_ready(out_ready && (sel == 2'(g))),
      .out_data (odl),
      .busy     (bzl)
    );

    assign p11 = a11 * b11 + a12 * b21;
    assign p12 = a11 * b12 + a12 * b22;
    assign p21 = a21 * b11 + a22 * b21;
    assign p22 = a21 * b12 + a22 * b22;

    // result is sampled CORE_LAT edges after the operand edge
    if (L == 1) begin : comb_core
      assign {c11, c12, c21, c22} = {p11, p12, p21, p22};
    end else begin : pipe_core
      logic [127:0] d [L-1];
      always @(posedge clk) begin
        d[0] <= {p11, p12, p21, p22};
        for (int k = 1; k < L - 1; k++)
          d[k] <= d[k-1];
      end
      assign {c11, c12, c21, c22} = d[L-2];
    end

    assign ov_v[g] = ovl;
    assign ir_v[g] = irl;
    assign bz_v[g] = bzl;
    assign od_v[g] = odl;
    assign cz_v[g] = |{a11, a12, a21, a22, b11, b12, b21, b22};
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp_v);
    end
  endtask

  function automatic int lat_of(input logic [1:0] s);
    return (s == 2'd0) ? 3 : (s == 2'd1) ? 1 : 8;
  endfunction

  task automatic load_job(input vec_t v, output int t_last);
    int n;
    for (int k = 0; k < 32; k++) begin
      in_valid = 1'b1;
      in_data  = (k < 16) ? v.a[k] : v.b[k-16];
      n = 0;
      while (!ir && n < 200) begin
        @(posedge clk); #1;
        n++;
      end
      if (!ir) begin
        chk("load_ready", {31'd0, ir}, 32'd1);
        break;
      end
      @(posedge clk); #1;
    end
    t_last   = cyc;
    in_valid = v.hold;
    in_data  = 32'hDEAD_BEEF;
  endtask

  task automatic wait_valid(input vec_t v, input int t_last);
    int n, bad;
    n = 0;
    bad = 0;
    chk("busy_compute", {31'd0, bz}, 32'd1);
    chk("ready_compute", {31'd0, ir}, 32'd0);
    while (!ov && n < 300) begin
      @(posedge clk); #1;
      n++;
      if (ir) bad++;
    end
    chk("rise_latency", 32'(cyc - t_last), 32'(lat_of(v.sel) + 9));
    if (v.hold)
      chk("hold_ready_low", 32'(bad), 32'd0);
    in_valid = 1'b0;
  endtask

  task automatic read_out(input vec_t v);
    int w, n;
    logic [31:0] prev;
    logic stalled, rdy;
    w = 0;
    n = 0;
    stalled = 1'b0;
    prev = '0;
    while (w < 16 && n < 2000) begin
      if (!ov) begin
        chk("out_valid_held", {31'd0, ov}, 32'd1);
        break;
      end
      if (stalled)
        chk("stall_stable", od, prev);
      rdy = ($urandom_range(0, 99) < 32'(v.rdy_pct));
      out_ready = rdy;
      prev = od;
      @(posedge clk); #1;
      n++;
      if (rdy) begin
        chk($sformatf("c%0d", w), prev, v.c[w]);
        w++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
      end
    end
    out_ready = 1'b0;
    chk("words_out", 32'(w), 32'd16);
    chk("ov_drop", {31'd0, ov}, 32'd0);
    chk("idle_ready", {31'd0, ir}, 32'd1);
    chk("idle_busy", {31'd0, bz}, 32'd0);
  endtask

  task automatic run_job(input vec_t v);
    int t_last;
    sel = v.sel;
    #1;
    load_job(v, t_last);
    wait_valid(v, t_last);
    read_out(v);
  endtask

  logic [15:0][31:0] m_id, m_seq, m_one, m_four, m_zero;
  logic [15:0][31:0] m_a8, m_b2, m_aff, m_b11, m_cfe;
  vec_t vecs [7];
  vec_t v_ones, v_idid;

  initial begin
    for (int k = 0; k < 16; k++) begin
      m_id[k]   = (k % 5 == 0) ? 32'd1 : 32'd0;
      m_seq[k]  = 32'(k + 1);
      m_one[k]  = 32'd1;
      m_four[k] = 32'd4;
      m_zero[k] = 32'd0;
    end
    m_a8 = m_zero;  m_a8[0] = 32'h8000_0000;
    m_b2 = m_zero;  m_b2[0] = 32'd2;
    m_aff = m_zero; m_aff[0] = 32'hFFFF_FFFF; m_aff[2] = 32'hFFFF_FFFF;
    m_b11 = m_zero; m_b11[0] = 32'd1; m_b11[8] = 32'd1;
    m_cfe = m_zero; m_cfe[0] = 32'hFFFF_FFFE;

    vecs[0] = '{a: m_id,  b: m_seq, c: m_seq,  sel: 2'd0, rdy_pct: 8'd100, hold: 1'b0};
    vecs[1] = '{a: m_one, b: m_one, c: m_four, sel: 2'd0, rdy_pct: 8'd100, hold: 1'b0};
    vecs[2] = '{a: m_a8,  b: m_b2,  c: m_zero, sel: 2'd0, rdy_pct: 8'd100, hold: 1'b0};
    vecs[3] = '{a: m_aff, b: m_b11, c: m_cfe,  sel: 2'd0, rdy_pct: 8'd100, hold: 1'b0};
    vecs[4] = '{a: m_id,  b: m_seq, c: m_seq,  sel: 2'd0, rdy_pct: 8'd30,  hold: 1'b1};
    vecs[5] = '{a: m_id,  b: m_seq, c: m_seq,  sel: 2'd1, rdy_pct: 8'd100, hold: 1'b0};
    vecs[6] = '{a: m_id,  b: m_seq, c: m_seq,  sel: 2'd2, rdy_pct: 8'd100, hold: 1'b0};
    v_ones  = '{a: m_one, b: m_one, c: m_four, sel: 2'd0, rdy_pct: 8'd100, hold: 1'b0};
    v_idid  = '{a: m_id,  b: m_id,  c: m_id,   sel: 2'd0, rdy_pct: 8'd100, hold: 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, ir}, 32'd1);
    chk("rst_out_valid", {31'd0, ov}, 32'd0);
    chk("rst_out_data", od, 32'd0);
    chk("rst_busy", {31'd0, bz}, 32'd0);
    chk("rst_core", {31'd0, cz}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int t = 0; t < 7; t++)
      run_job(vecs[t]);

    begin
      int t_last;
      sel = 2'd0;
      #1;
      load_job(v_ones, t_last);
      repeat (4) begin
        @(posedge clk); #1;
      end
      chk("mid_issue_core", {31'd0, cz}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_ready", {31'd0, ir}, 32'd1);
      chk("arst_busy", {31'd0, bz}, 32'd0);
      chk("arst_core", {31'd0, cz}, 32'd0);
      chk("arst_valid", {31'd0, ov}, 32'd0);
      @(posedge clk); #3;
      rst = 1'b0;
      @(posedge clk); #1;
    end
    run_job(v_idid);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mat4_block_sequencer.md
# mat4_block_sequencer

Initiator-side controller for the 2x2 Strassen multiplier core. It loads two 4x4 matrices from a word stream and decomposes A*B into eight 2x2 block products, which it issues to the core back-to-back. It then accumulates the returned blocks and streams out the 4x4 result. It sits between the system word bus and the core, and drives the core's operand ports and consumes its result ports.

## Interface
- W, 32, element width; all arithmetic is modulo 2^W.
- CORE_LAT, 3, cycles from operands on core_a*/core_b* to the matching valid result on core_c*; legal range 1..8.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input word valid.
- in_ready  out  1  sequencer accepts a word (LOAD state only).
- in_data  in  W  word: A row-major (16 words), then B row-major (16 words).
- core_a11, core_a12, core_a21, core_a22  out  W each  A block operand to core.
- core_b11, core_b12, core_b21, core_b22  out  W each  B block operand to core.
- core_c11, core_c12, core_c21, core_c22  in  W each  product block from core.
- out_valid  out  1  result word valid.
- out_ready  in  1  downstream accepts result word.
- out_data  out  W  C row-major, 16 words.
- busy  out  1  high in ISSUE, DRAIN and OUTPUT.

## Operation
- Reset values: in_ready=1, out_valid=0, out_data=0, busy=0, all core_* outputs=0; word counter=0; state=LOAD.
- LOAD:
  - Transfer when in_valid&&in_ready. Word k (0..31) is written to A[k/4][k%4] for k<16, else B[(k-16)/4][k%4].
  - After word 31 the state goes to ISSUE; in_ready drops on the following cycle.
- ISSUE: exactly 8 cycles, one block product per cycle.
  - Issue order is (i,j,kk): (0,0,0),(0,0,1),(0,1,0),(0,1,1),(1,0,0),(1,0,1),(1,1,0),(1,1,1).
  - Product operands are A block (i,kk) and B block (kk,j); block (r,c) covers rows 2r..2r+1 and columns 2c..2c+1.
  - Operands are registered. Outside ISSUE, the core_* outputs are driven to 0.
- Tag pipeline: a CORE_LAT-deep shift register carries {valid, i, j, kk} alongside each issue.
  - When the tag emerges valid, the core_c* values are captured into C block (i,j).
  - kk=0 overwrites the block. kk=1 adds to it (wrap modulo 2^W, no saturation, no overflow flag).
- DRAIN: waits until the tag pipeline is empty, then goes to OUTPUT. Its duration is CORE_LAT cycles after the last issue.
- OUTPUT:
  - Presents C row-major, 16 words, with out_valid held high. The word index advances only on out_valid&&out_ready.
  - out_data is stable while out_valid&&!out_ready.
  - After word 15 transfers, out_valid=0 on the next cycle and the state returns to LOAD with the counter cleared.
- in_valid outside LOAD is ignored (in_ready=0); no words are lost or buffered.
- Reset mid-operation, in any state: immediate return to reset values. The tag pipeline is flushed and core results still in flight are discarded.
- Sequence on each matrix pair is LOAD → ISSUE → DRAIN → OUTPUT → LOAD. There is no overlap between jobs.

## Timing
- The last input word is accepted at edge T. The first core operands are visible after edge T+1, and the eighth after edge T+8.
- The last capture occurs at edge T+8+CORE_LAT. out_valid rises after edge T+9+CORE_LAT.
- Minimum job time, with no stalls: 32 load + 8 issue + CORE_LAT drain + 1 + 16 output cycles (60 cycles at CORE_LAT=3).
- The core is assumed fully pipelined: a new operand set every cycle, with a result exactly CORE_LAT cycles later.

## Structure
- Shared package mat_pkg holds:
  - W default, MAT_N=4, TILE=2;
  - state enum {LOAD, ISSUE, DRAIN, OUTPUT};
  - the tag struct {valid, i, j, kk}.
- One sub-module, mat_tag_pipe: a parameterised CORE_LAT-deep valid/tag delay line with asynchronous reset and a flush on reset.
- The Strassen core is instantiated at the level above and is not inside this block.

## Test plan
- A = identity, B[r][c]=4r+c+1 → C equals B (1..16 row-major); out_valid rises exactly CORE_LAT+9 cycles after the last input.
- A = B = all ones → all 16 outputs = 4.
- Wrap: A[0][0]=0x8000_0000, B[0][0]=2, all else 0 → C[0][0]=0 and every other word 0. Also A[0][0]=A[0][2]=0xFFFF_FFFF, B[0][0]=B[2][0]=1 → C[0][0]=0xFFFF_FFFE (kk accumulate wrap).
- Backpressure: random out_ready at 30% duty, A = identity, B=1..16 → exact order 1..16, no duplicates, out_data stable during stalls; in_valid held high during compute → in_ready=0 and no corruption.
- Reset asserted asynchronously in the middle of ISSUE (after 4 issues), then a new job with A = B = identity → output identity; no stale results from the flushed products.
- Repeat the identity test at CORE_LAT=1 and CORE_LAT=8 with a behavioural core model → correct C, and issue-to-capture spacing equals CORE_LAT.
